// File: rtl/pe_nic.sv
// Network interface between a processor register port and one router PE port.
// It holds a single-packet output buffer (processor to router) and a single-packet input buffer (router to processor).
module pe_nic (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic [63:0] d_in,
  output logic [63:0] d_out,
  input  logic        nicEn,
  input  logic        nicWrEn,
  output logic        net_so,
  input  logic        net_ro,
  output logic [63:0] net_do,
  input  logic        net_polarity,
  input  logic        net_si,
  output logic        net_ri,
  input  logic [63:0] net_di
);

  // Handshakes: a packet moves toward the router on an edge where out_full && net_ro
  // && (out_buf[63] == net_polarity). It is then announced by a one-cycle net_so with net_do.
  // A packet moves from the router on an edge where net_si && net_ri. Strobes while not ready are ignored.
  localparam logic [1:0] ADDR_IN_BUF     = 2'd0;
  localparam logic [1:0] ADDR_IN_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_OUT_BUF    = 2'd2;
  localparam logic [1:0] ADDR_OUT_STATUS = 2'd3;

  logic [63:0] out_buf;
  logic        out_full;
  logic [63:0] in_buf;
  logic        in_full;

  logic wr_accept;
  logic inject;
  logic eject;
  logic rd_clear;

  assign wr_accept = nicEn && nicWrEn && (addr == ADDR_OUT_BUF) && !out_full;
  assign inject    = out_full && net_ro && (out_buf[63] == net_polarity);
  assign eject     = net_si && !in_full;
  assign rd_clear  = nicEn && !nicWrEn && (addr == ADDR_IN_BUF) && in_full;
  assign net_ri    = ~in_full;

  // wr_accept needs an empty buffer and inject needs a full one, so they never collide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_buf  <= '0;
      out_full <= 1'b0;
      net_so   <= 1'b0;
      net_do   <= '0;
    end else begin
      net_so <= inject;
      if (inject) begin
        net_do   <= out_buf;
        out_full <= 1'b0;
      end else if (wr_accept) begin
        out_buf  <= d_in;
        out_full <= 1'b1;
      end
    end
  end

  // eject needs an empty buffer and rd_clear needs a full one, so they never collide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_buf  <= '0;
      in_full <= 1'b0;
    end else begin
      if (eject) begin
        in_buf  <= net_di;
        in_full <= 1'b1;
      end else if (rd_clear) begin
        in_full <= 1'b0;
      end
    end
  end

  always_comb begin
    d_out = '0;
    if (nicEn && !nicWrEn) begin
      case (addr)
        ADDR_IN_BUF:     d_out = in_buf;
        ADDR_IN_STATUS:  d_out = {63'b0, in_full};
        ADDR_OUT_BUF:    d_out = '0;
        ADDR_OUT_STATUS: d_out = {63'b0, out_full};
        default:         d_out = '0;
      endcase
    end
  end

endmodule

// File: doc/pe_nic.md
PE_NIC -- requirements
Module: pe_nic

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: addr  in  2  processor register select (0 in_buf, 1 in_status, 2 out_buf, 3 out_status).
REQ-004 SHALL have ports: d_in  in  64  processor write data.
REQ-005 SHALL have ports: d_out  out  64  processor read data.
REQ-006 SHALL have ports: nicEn  in  1  processor access enable.
REQ-007 SHALL have ports: nicWrEn  in  1  1 = write, 0 = read; qualified by nicEn.
REQ-008 SHALL have ports: net_so  out  1  send strobe into router PE input.
REQ-009 SHALL have ports: net_ro  in  1  router PE input ready.
REQ-010 SHALL have ports: net_do  out  64  packet into router PE input.
REQ-011 SHALL have ports: net_polarity  in  1  router polarity_out, toggles every cycle.
REQ-012 SHALL have ports: net_si  in  1  send strobe from router PE output.
REQ-013 SHALL have ports: net_ri  out  1  NIC ready to accept from router.
REQ-014 SHALL have ports: net_di  in  64  packet from router PE output.

Function
REQ-015 SHALL hold one 64-bit output buffer (out_buf, out_full) and one 64-bit input buffer (in_buf, in_full); packet contents pass unmodified, bit 63 = VC.
REQ-016 Processor write: at an edge with nicEn=1, nicWrEn=1, addr=2, out_full=0 -> out_buf<=d_in, out_full<=1; if out_full=1 the write SHALL be dropped with no state change.
REQ-017 Writes to addr 0, 1, 3 SHALL be ignored.
REQ-018 Injection: at an edge with out_full=1, net_ro=1, out_buf[63]==net_polarity -> net_so<=1, net_do<=out_buf, out_full<=0; otherwise net_so<=0 and net_do holds its last value.
REQ-019 net_so SHALL be high for exactly one cycle per packet; out_buf[63]!=net_polarity SHALL stall at most one cycle while net_ro=1.
REQ-020 A write accepted at edge N SHALL be injectable no earlier than edge N+1 (min. write-to-net_so latency 1 cycle, max 2 with net_ro=1).
REQ-021 Write and injection on the same edge: the write sees pre-edge out_full=1 and SHALL be dropped.
REQ-022 net_ri SHALL equal ~in_full combinationally.
REQ-023 Ejection: at an edge with net_si=1 and in_full=0 -> in_buf<=net_di, in_full<=1; net_si=1 while in_full=1 SHALL be ignored (protocol violation, no overwrite).
REQ-024 Processor read (nicEn=1, nicWrEn=0), combinational d_out: addr0 = in_buf; addr1 = {63'b0,in_full}; addr2 = 64'b0; addr3 = {63'b0,out_full}.
REQ-025 d_out SHALL be 64'b0 when nicEn=0 or nicWrEn=1.
REQ-026 Reading addr 0 with in_full=1 SHALL clear in_full at that edge; net_ri rises the following cycle; reading addr 0 with in_full=0 returns stale in_buf, no state change.
REQ-027 Read-clear and arrival cannot coincide (net_ri=0 while full); arrival earliest one cycle after clear.
REQ-028 Injection and ejection paths SHALL operate independently in the same cycle.

Reset
REQ-029 reset=0 SHALL immediately and asynchronously clear out_full, in_full, net_so, net_do, in_buf, out_buf to 0; net_ri=1, d_out follows REQ-024/025.
REQ-030 Reset asserted mid-operation SHALL discard buffered packets; no net_so pulse occurs after deassertion until a new write.
REQ-031 State SHALL resume updating on the first rising edge after reset returns to 1.

Verification
REQ-032 Write 64'h200200000000FA50 to addr 2, net_ro=1, polarity toggling -> single net_so pulse with net_do=64'h200200000000FA50 within 2 cycles at the cycle where polarity=0; addr 3 then reads 0.
REQ-033 Write 64'hC012000000000001 with net_ro=0 for 5 cycles, then net_ro=1 -> no net_so while net_ro=0, one pulse on the first polarity=1 edge after release; second write while full is dropped.
REQ-034 Router drives net_si=1, net_di=64'h001000000000C7D4 -> net_ri falls next cycle; addr1 reads 1; addr0 read returns 64'h001000000000C7D4; net_ri=1 the cycle after.
REQ-035 Second net_si with 64'h0000000000000DDA while in_full=1 -> in_buf remains 64'h001000000000C7D4.
REQ-036 Concurrent inject of 64'h0002000000053FDA and eject of 64'h40100000FFFFFFFF -> both complete, no interaction.
REQ-037 Assert reset low asynchronously between edges with both buffers full -> net_ri=1, addr1/addr3 read 0, net_so=0 immediately, no later net_so.
